// File: rtl/rio_stream_pkg.sv
// rio_stream_pkg: shared stream widths, FSM encoding and packet rounding helpers for the RapidIO NWRITE path.
package rio_stream_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int DATA_LENGTH_WIDTH = 20;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  function automatic logic [5:0] round_beats(input logic [7:0] t);
    return t < 8'd16 ? 6'd2 : t < 8'd32 ? 6'd4 : t < 8'd64 ? 6'd8 : t < 8'd128 ? 6'd16 : 6'd32;
  endfunction
  function automatic logic [7:0] last_keep(input logic [2:0] l);
    return 8'hFF >> (3'd7 - l);
  endfunction
endpackage

// File: rtl/rio_sync_fifo.sv
// rio_sync_fifo: synchronous first-word-fall-through FIFO; output reads as zero while empty.
module rio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_en,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0] wptr, rptr;
  assign empty = wptr == rptr;
  assign full = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) && (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign rd_data = empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + 1'b1;
      if (rd_en && !empty) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr_en && !full) mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
endmodule

// File: rtl/output_writer.sv
// output_writer: rebuilds the user byte stream from padded 256-byte NWRITE packets.
// Optional packet-length checking is enabled by defining OUTPUT_WRITER_LEN_CHECK_EN.
module output_writer
  import rio_stream_pkg::*;
#(
  parameter int DATA_WIDTH = rio_stream_pkg::DATA_WIDTH,
  parameter int DATA_LENGTH_WIDTH = rio_stream_pkg::DATA_LENGTH_WIDTH,
  parameter int FIFO_ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  input  logic [DATA_LENGTH_WIDTH-1:0] cmd_len,
  output logic                         cmd_ready,
  input  logic [DATA_WIDTH-1:0]        in_tdata,
  input  logic                         in_tvalid,
  input  logic                         in_tfirst,
  input  logic                         in_tlast,
  output logic                         in_tready,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid_out,
  output logic                         data_first_out,
  output logic [DATA_WIDTH/8-1:0]      data_keep_out,
  output logic                         data_last_out,
  input  logic                         data_ready_in,
  output logic                         done_o,
  output logic                         len_err_o
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int LW = DATA_LENGTH_WIDTH;
  localparam int BW = LW - 3;
  localparam int PW = LW - 8;
  localparam int FW = DATA_WIDTH + KW + 2;
  logic [1:0] state;
  logic [LW-1:0] len_reg;
  logic [BW-1:0] beat_cnt;
  logic [PW-1:0] pkt_cnt;
  logic [BW:0] p_beats;
  logic [PW:0] n_pkts;
  logic [5:0] t_beats;
  logic final_pkt, hs, accept, pop, tag_last, full, empty, last_done;
  logic [KW-1:0] keep;
  logic [FW-1:0] rd_data;
  assign p_beats = {1'b0, len_reg[LW-1:3]} + 1'b1;
  assign n_pkts = {1'b0, len_reg[LW-1:8]} + 1'b1;
  assign t_beats = round_beats(len_reg[7:0]);
  assign final_pkt = {1'b0, pkt_cnt} == n_pkts - 1'b1;
  assign tag_last = {1'b0, beat_cnt} == p_beats - 1'b1;
  assign keep = tag_last ? KW'(last_keep(len_reg[2:0])) : '1;
  assign cmd_ready = state == IDLE;
  assign in_tready = state == RECV && !full;
  assign hs = in_tvalid && in_tready;
  assign accept = cmd_valid && cmd_ready;
  assign data_valid_out = !empty;
  assign pop = data_valid_out && data_ready_in;
  assign done_o = state == DRAIN && empty && last_done;
  assign {data_first_out, data_last_out, data_keep_out, data_out} = rd_data;
  // pad beats past the payload count are accepted but never stored
  rio_sync_fifo #(.WIDTH(FW), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_data({beat_cnt == '0, tag_last, keep, in_tdata}),
    .wr_en(hs && {1'b0, beat_cnt} < p_beats),
    .full(full),
    .rd_data(rd_data),
    .rd_en(pop),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      len_reg <= '0;
      beat_cnt <= '0;
      pkt_cnt <= '0;
      last_done <= 1'b0;
    end else begin
      if (accept) begin
        state <= RECV;
        len_reg <= cmd_len;
        beat_cnt <= '0;
        pkt_cnt <= '0;
        last_done <= 1'b0;
      end
      if (hs) beat_cnt <= beat_cnt + 1'b1;
      if (hs && in_tlast) begin
        pkt_cnt <= pkt_cnt + 1'b1;
        if (final_pkt) state <= DRAIN;
      end
      if (pop && data_last_out) last_done <= 1'b1;
      if (done_o) state <= IDLE;
    end
`ifdef OUTPUT_WRITER_LEN_CHECK_EN
  logic [4:0] pkt_beat, exp_last;
  logic bad;
  assign exp_last = final_pkt ? 5'(t_beats - 6'd1) : 5'd31;
  assign bad = hs && ((in_tfirst != (pkt_beat == 5'd0)) || (in_tlast != (pkt_beat == exp_last)));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pkt_beat <= '0;
      len_err_o <= 1'b0;
    end else if (accept) begin
      pkt_beat <= '0;
      len_err_o <= 1'b0;
    end else begin
      if (hs) pkt_beat <= in_tlast ? 5'd0 : pkt_beat + 5'd1;
      if (bad) len_err_o <= 1'b1;
    end
`else
  logic unused_check;
  assign unused_check = ^{in_tfirst, t_beats};
  assign len_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_output_writer.sv
// tb_output_writer: scoreboard bench for output_writer with a small FIFO to force backpressure.
module tb_output_writer;
  typedef struct packed {
    logic [63:0] d;
    logic f;
    logic l;
    logic [7:0] k;
  } beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [19:0] cmd_len = '0;
  logic cmd_ready;
  logic [63:0] in_tdata = '0;
  logic in_tvalid = 1'b0;
  logic in_tfirst = 1'b0;
  logic in_tlast = 1'b0;
  logic in_tready;
  logic [63:0] data_out;
  logic data_valid_out, data_first_out, data_last_out, done_o, len_err_o;
  logic [7:0] data_keep_out;
  logic data_ready_in = 1'b0;
  beat_t sb[$];
  beat_t got_e;
  int checks = 0, errors = 0, pops = 0, dones = 0, stalls = 0, cyc = 0, rdy_mode = 0;
  logic exp_err;
  always #5 clk = ~clk;
  output_writer #(.DATA_WIDTH(64), .DATA_LENGTH_WIDTH(20), .FIFO_ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tfirst(in_tfirst), .in_tlast(in_tlast),
    .in_tready(in_tready), .data_out(data_out), .data_valid_out(data_valid_out),
    .data_first_out(data_first_out), .data_keep_out(data_keep_out), .data_last_out(data_last_out),
    .data_ready_in(data_ready_in), .done_o(done_o), .len_err_o(len_err_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1 data_ready_in = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ((cyc % 6) < 3) : 1'b0;
  end
  always @(negedge clk) begin
    if (data_valid_out && data_ready_in) begin
      if (sb.size() == 0) chk("extra_beat", 64'(data_out), 64'hDEAD_0000);
      else begin
        got_e = sb.pop_front();
        chk("data", data_out, got_e.d);
        chk("first", 64'(data_first_out), 64'(got_e.f));
        chk("last", 64'(data_last_out), 64'(got_e.l));
        chk("keep", 64'(data_keep_out), 64'(got_e.k));
      end
      pops <= pops + 1;
    end
    if (done_o) dones <= dones + 1;
    if (in_tvalid && !in_tready && !reset) stalls <= stalls + 1;
  end
  task automatic start_cmd(input logic [19:0] len);
    int w = 0;
    @(posedge clk);
    #1 cmd_valid = 1'b1;
    cmd_len = len;
    do begin @(negedge clk); w++; end while (!cmd_ready && w < 300);
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic send_beat(input logic [63:0] d, input logic f, input logic l, input bit pay, input beat_t e);
    int n = 0;
    in_tdata = d;
    in_tfirst = f;
    in_tlast = l;
    in_tvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_tready && n < 300);
    if (!in_tready) chk("tready_timeout", 64'd0, 64'd1);
    else if (pay) sb.push_back(e);
    @(posedge clk);
    #1 in_tvalid = 1'b0;
  endtask
  task automatic run(input logic [19:0] len, input int fin_ovr, input int id);
    int p, n, t, tb_beats, nb, idx, w;
    int d0, p0;
    logic [7:0] lk;
    beat_t e;
    d0 = dones;
    p0 = pops;
    idx = 0;
    p = int'(len >> 3) + 1;
    n = int'(len >> 8) + 1;
    t = int'(len & 20'hFF);
    tb_beats = t < 16 ? 2 : t < 32 ? 4 : t < 64 ? 8 : t < 128 ? 16 : 32;
    if (fin_ovr != 0) tb_beats = fin_ovr;
    lk = 8'((1 << (int'(len & 20'h7) + 1)) - 1);
    start_cmd(len);
    for (int pk = 0; pk < n; pk++) begin
      nb = pk < n - 1 ? 32 : tb_beats;
      for (int b = 0; b < nb; b++) begin
        e.d = {8'(id), 24'h5A5A00, 32'(idx)};
        e.f = idx == 0;
        e.l = idx == p - 1;
        e.k = idx == p - 1 ? lk : 8'hFF;
        send_beat(e.d, b == 0, b == nb - 1, idx < p, e);
        idx++;
      end
    end
    w = 0;
    while (dones == d0 && w < 2000) begin @(posedge clk); w++; end
    repeat (4) @(posedge clk);
    chk("done_once", 64'(dones - d0), 64'd1);
    chk("user_beats", 64'(pops - p0), 64'(p));
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
`ifdef OUTPUT_WRITER_LEN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_outs", 64'({in_tready, data_valid_out, data_first_out, data_last_out, data_keep_out, done_o, len_err_o}), 64'd0);
    chk("rst_data", data_out, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run(20'h007, 0, 1);
    chk("len_err_ok1", 64'(len_err_o), 64'd0);
    run(20'h104, 0, 2);
    run(20'h13F, 0, 3);
    rdy_mode = 1;
    begin
      int s0;
      s0 = stalls;
      run(20'h3FF, 0, 4);
      chk("stall_seen", 64'(stalls > s0), 64'd1);
    end
    rdy_mode = 0;
    run(20'h104, 4, 5);
    chk("len_err_set", 64'(len_err_o), 64'(exp_err));
    repeat (5) @(posedge clk);
    chk("len_err_hold", 64'(len_err_o), 64'(exp_err));
    run(20'h007, 0, 6);
    chk("len_err_clear", 64'(len_err_o), 64'd0);
    rdy_mode = 2;
    start_cmd(20'h3FF);
    for (int i = 0; i < 4; i++) begin
      beat_t e;
      e.d = {8'd7, 24'h0, 32'(i)};
      e.f = i == 0;
      e.l = 1'b0;
      e.k = 8'hFF;
      send_beat(e.d, i == 0, 1'b0, 1'b1, e);
    end
    @(negedge clk);
    chk("pre_reset_valid", 64'(data_valid_out), 64'd1);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_outs", 64'({in_tready, data_valid_out, data_first_out, data_last_out, data_keep_out, done_o, len_err_o}), 64'd0);
    chk("mid_rst_data", data_out, 64'd0);
    sb.delete();
    rdy_mode = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    run(20'h00C, 0, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_writer.md
Name: output_writer

Overview:
- Receive-side counterpart of the user-to-NWR packetiser. Accepts the 256-byte-segmented, pad-rounded packet stream arriving from the RapidIO NWRITE target and rebuilds the original user byte stream.
- Drops pad beats, regenerates first/last/keep on the user side, buffers through an internal FIFO, and pulses done when the transfer has been fully delivered.

Parameters:
DATA_WIDTH, 64, stream width in bits; the keep width is DATA_WIDTH/8.
DATA_LENGTH_WIDTH, 20, width of the byte-length fields.
FIFO_ADDR_WIDTH, 6, log2 of the FIFO depth in beats.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  transfer start strobe; sampled only in IDLE
cmd_len  in  DATA_LENGTH_WIDTH  user byte count minus 1
cmd_ready  out  1  high in IDLE
in_tdata  in  DATA_WIDTH  packet data from NWR target
in_tvalid  in  1  packet beat valid
in_tfirst  in  1  first beat of a packet
in_tlast  in  1  last beat of a packet
in_tready  out  1  packet beat accept
data_out  out  DATA_WIDTH  user data
data_valid_out  out  1  user beat valid
data_first_out  out  1  first user beat of the transfer
data_keep_out  out  DATA_WIDTH/8  byte-lane enables, bit i = lane i
data_last_out  out  1  final user beat
data_ready_in  in  1  user sink ready
done_o  out  1  one-cycle pulse after the final user beat handshakes
len_err_o  out  1  sticky packet-length error (optional feature)

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1; state=IDLE; counters and FIFO pointers 0; len_err_o=0.
- FSM states: IDLE, RECV, DRAIN.
  - IDLE: cmd_valid -> latch cmd_len into len_reg, clear counters, go to RECV.
  - RECV: in_tready = ~fifo_full. Handshake = in_tvalid & in_tready. Leave RECV when the handshake carries in_tlast and the packet is the final packet; go to DRAIN.
  - DRAIN: in_tready=0. Go to IDLE once the FIFO is empty and the beat tagged last has handshaked; done_o pulses in that same transition cycle.
- Derived lengths, computed combinationally from len_reg:
  - payload beats P = len_reg[DLW-1:3]+1.
  - packets N = len_reg[DLW-1:8]+1.
  - tail t = len_reg[7:0]; tail packet beats T = 2 if t<16, 4 if t<32, 8 if t<64, 16 if t<128, else 32.
  - Every non-final packet is 32 beats.
- Counters:
  - beat_cnt (DLW-3 bits) increments on each input handshake.
  - pkt_cnt increments on each handshake with in_tlast.
- Input beat handling:
  - Payload beat (beat_cnt < P): written to the FIFO with a first tag (beat_cnt==0) and a last tag (beat_cnt==P-1).
  - Pad beat (beat_cnt >= P): accepted and discarded, never written.
- Keep: non-last beats get all ones. The last beat gets (1<<(len_reg[2:0]+1))-1, so len_reg[2:0]=7 gives 0xFF.
- FIFO:
  - Synchronous, first-word-fall-through, registered output.
  - data_valid_out = ~empty. A pop occurs on data_valid_out & data_ready_in.
  - One cycle of latency from input handshake to data_valid_out when the FIFO is empty.
  - Pointers are FIFO_ADDR_WIDTH+1 bits wide; full/empty are decided by MSB compare.
  - Simultaneous push and pop when full is not allowed, because in_tready is already low.
- Output data stays stable while data_valid_out & ~data_ready_in.
- in_tfirst is used only by the length check; the packet framing itself is counter-based.
- cmd_valid outside IDLE is ignored.
- Asserting reset mid-transfer discards FIFO contents immediately and returns the FSM to IDLE.

Optional Feature:
- Macro OUTPUT_WRITER_LEN_CHECK_EN.
- When defined, a packet beat counter (5 bits) checks each packet:
  - in_tlast must arrive at beat 31 for non-final packets and at beat T-1 for the final packet.
  - in_tfirst must coincide with beat 0.
  - Any mismatch sets len_err_o, which stays set until reset or the next cmd_valid accept. Data flow is unchanged.
- When undefined: len_err_o is tied to 0 and the packet counter is not instantiated.

Decomposition:
- Shared package rio_stream_pkg holds:
  - DATA_WIDTH and DATA_LENGTH_WIDTH defaults;
  - the state encoding;
  - function round_beats(t), returning T;
  - function last_keep(len[2:0]).
- The same rounding function is reused by the transmit packetiser.
- The FIFO is a natural sub-module, rio_sync_fifo: parameterised width and depth, FWFT, full/empty outputs.

Test Plan:
- cmd_len=0x007, one 2-beat packet -> one user beat with first=last=1 and keep=0xFF; the pad beat is dropped; done_o pulses once.
- cmd_len=0x104, packets of 32 then 2 beats -> 33 user beats; last keep=0x1F; 1 pad beat dropped.
- cmd_len=0x13F, packets of 32 then 8 beats -> 40 user beats, no padding; last keep=0xFF; first tag on beat 0 only.
- cmd_len=0x3FF with data_ready_in toggling every 3 cycles and FIFO_ADDR_WIDTH=2 -> in_tready deasserts when full; the 128 beats arrive in order with no loss or duplication.
- Macro defined, cmd_len=0x104, final packet tlast at beat 3 -> len_err_o=1 and it holds until the next cmd accept.
- Reset asserted while in RECV -> next cycle all outputs are at reset values and cmd_ready=1.
